// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the two-port DDR arbiter: FSM state encoding and requester indices.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational grant selection between the data and instruction requesters.
module ddr_arb_pick
  import ddr_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Contention goes to whichever port was not served last.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = PORT_I;
    end else begin
      grant_idx = PORT_D;
    end
  end

endmodule

// File: rtl/ddr_mem_arbiter.sv
// Two-requester arbiter in front of a single DDR memory port, one transaction at a time.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port 0 has fixed priority.
module ddr_mem_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                            ui_clk,
  input  logic                            ui_rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   p0_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   p0_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] p0_wmask,
  input  logic                            p0_wen,
  input  logic                            p0_ren,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   p0_rdata,
  output logic                            p0_valid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   p1_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   p1_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] p1_wmask,
  input  logic                            p1_wen,
  input  logic                            p1_ren,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   p1_rdata,
  output logic                            p1_valid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_mem,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_mem,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] wmask_mem,
  output logic                            wen_mem,
  output logic                            ren_mem,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_mem,
  input  logic                            valid_mem,
  output logic [1:0]                      debug_arb_state,
  output logic                            debug_arb_grant
);

  localparam int MW = C_S_AXI_DATA_WIDTH / 8;

  arb_state_t                    state;
  logic                          grant;
  logic                          grant_valid;
  logic                          grant_idx;
  logic                          last_served;

  logic [C_S_AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] sel_wdata;
  logic [MW-1:0]                 sel_wmask;
  logic                          sel_wen;

  logic [C_S_AXI_ADDR_WIDTH-1:0] lat_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] lat_wdata;
  logic [MW-1:0]                 lat_wmask;
  logic                          lat_wr;

  ddr_arb_pick u_pick (
    .req0        (p0_wen | p0_ren),
    .req1        (p1_wen | p1_ren),
    .last_grant  (last_served),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifndef DDR_ARB_ROUND_ROBIN_EN
  // Pretending port 1 was always served last makes the picker favour port 0.
  assign last_served = PORT_I;
`endif

  always_comb begin
    if (grant_idx == PORT_I) begin
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
      sel_wmask = p1_wmask;
      sel_wen   = p1_wen;
    end else begin
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
      sel_wmask = p0_wmask;
      sel_wen   = p0_wen;
    end
  end

  // Reads carry zero data/mask downstream, so the latched copies are zeroed at grant time.
  assign addr_mem        = lat_addr;
  assign wdata_mem       = lat_wdata;
  assign wmask_mem       = lat_wmask;
  assign debug_arb_state = state;
  assign debug_arb_grant = grant;

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state     <= IDLE;
      grant     <= PORT_D;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_wr    <= 1'b0;
      wen_mem   <= 1'b0;
      ren_mem   <= 1'b0;
      p0_valid  <= 1'b0;
      p1_valid  <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_served <= PORT_I;
`endif
    end else begin
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant     <= grant_idx;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wen ? sel_wdata : '0;
            lat_wmask <= sel_wen ? sel_wmask : '0;
            lat_wr    <= sel_wen;
            wen_mem   <= sel_wen;
            ren_mem   <= ~sel_wen;
            state     <= BUSY;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            last_served <= grant_idx;
`endif
          end
        end
        BUSY: begin
          if (valid_mem) begin
            wen_mem <= 1'b0;
            ren_mem <= 1'b0;
            state   <= DRAIN;
            if (grant == PORT_I) begin
              p1_valid <= 1'b1;
              if (!lat_wr) p1_rdata <= rdata_mem;
            end else begin
              p0_valid <= 1'b1;
              if (!lat_wr) p0_rdata <= rdata_mem;
            end
          end
        end
        DRAIN: begin
          if (!valid_mem) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_mem_arbiter.sv
// Self-checking bench for ddr_mem_arbiter: vector table plus arbitration and reset sequences.
module tb_ddr_mem_arbiter;

  logic        ui_clk;
  logic        ui_rst_n;
  logic [63:0] p0_addr, p1_addr, p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic [7:0]  p0_wmask, p1_wmask;
  logic        p0_wen, p1_wen, p0_ren, p1_ren, p0_valid, p1_valid;
  logic [63:0] addr_mem, wdata_mem, rdata_mem;
  logic [7:0]  wmask_mem;
  logic        wen_mem, ren_mem, valid_mem;
  logic [1:0]  debug_arb_state;
  logic        debug_arb_grant;

  typedef struct {
    logic        port;
    logic        wen;
    logic        ren;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          lat;
    int          hold;
  } exp_t;

  typedef struct {
    logic        port;
    logic        in_wen;
    logic        in_ren;
    logic [63:0] addr;
    logic [63:0] in_wdata;
    logic [7:0]  in_wmask;
    logic [63:0] mem_rdata;
    int          lat;
    int          hold;
    logic        exp_wen;
    logic        exp_ren;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  logic [63:0] prdata[2];
  int          arb_order[4];
  int          n_pass = 0;
  int          n_total = 0;
  bit          auto_drop = 1'b1;

  ddr_mem_arbiter dut (
    .ui_clk          (ui_clk),
    .ui_rst_n        (ui_rst_n),
    .p0_addr         (p0_addr),
    .p0_wdata        (p0_wdata),
    .p0_wmask        (p0_wmask),
    .p0_wen          (p0_wen),
    .p0_ren          (p0_ren),
    .p0_rdata        (p0_rdata),
    .p0_valid        (p0_valid),
    .p1_addr         (p1_addr),
    .p1_wdata        (p1_wdata),
    .p1_wmask        (p1_wmask),
    .p1_wen          (p1_wen),
    .p1_ren          (p1_ren),
    .p1_rdata        (p1_rdata),
    .p1_valid        (p1_valid),
    .addr_mem        (addr_mem),
    .wdata_mem       (wdata_mem),
    .wmask_mem       (wmask_mem),
    .wen_mem         (wen_mem),
    .ren_mem         (ren_mem),
    .rdata_mem       (rdata_mem),
    .valid_mem       (valid_mem),
    .debug_arb_state (debug_arb_state),
    .debug_arb_grant (debug_arb_grant)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input logic port, input logic wen, input logic ren,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask);
    if (port) begin
      p1_wen = wen; p1_ren = ren; p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask;
    end else begin
      p0_wen = wen; p0_ren = ren; p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask;
    end
  endtask

  task automatic clear_req(input logic port);
    set_req(port, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0);
  endtask

  task automatic push_exp(input logic port, input logic wen, input logic ren, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask, input logic [63:0] rdata,
                          input int lat, input int hold);
    exp_t e;
    e.port = port; e.wen = wen; e.ren = ren; e.addr = addr; e.wdata = wdata;
    e.wmask = wmask; e.rdata = rdata; e.lat = lat; e.hold = hold;
    sb.push_back(e);
  endtask

  // Acts as the memory for one granted transaction and checks it against the scoreboard head.
  task automatic serve_one(input int max_wait);
    exp_t e;
    int   waited;
    waited = 0;
    while (!(wen_mem || ren_mem) && waited < max_wait) begin
      tick();
      waited++;
    end
    if (!(wen_mem || ren_mem)) begin
      check("req_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_req", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("grant", debug_arb_grant, e.port);
    check("state_busy", debug_arb_state, 2'b01);
    check("wen_mem", wen_mem, e.wen);
    check("ren_mem", ren_mem, e.ren);
    check("addr_mem", addr_mem, e.addr);
    check("wdata_mem", wdata_mem, e.wdata);
    check("wmask_mem", wmask_mem, e.wmask);
    repeat (e.lat - 1) tick();
    check("req_stable", {wen_mem, ren_mem}, {e.wen, e.ren});
    check("no_early_valid", {p0_valid, p1_valid}, 2'b00);
    valid_mem = 1'b1;
    rdata_mem = e.rdata;
    tick();
    valid_mem = (e.hold > 0);
    check("p0_valid", p0_valid, (e.port == 1'b0));
    check("p1_valid", p1_valid, (e.port == 1'b1));
    if (e.ren) prdata[e.port] = e.rdata;
    check("p0_rdata", p0_rdata, prdata[0]);
    check("p1_rdata", p1_rdata, prdata[1]);
    check("mem_req_off", {wen_mem, ren_mem}, 2'b00);
    if (auto_drop) clear_req(e.port);
    for (int i = 0; i < e.hold; i++) begin
      tick();
      check("drain_state", debug_arb_state, 2'b10);
      check("drain_no_req", {wen_mem, ren_mem}, 2'b00);
      check("drain_no_valid", {p0_valid, p1_valid}, 2'b00);
    end
    valid_mem = 1'b0;
    tick();
    check("pulse_once", {p0_valid, p1_valid}, 2'b00);
    check("back_idle", debug_arb_state, 2'b00);
  endtask

  task automatic applyStimulus();
    vecs[0] = '{1'b0, 1'b0, 1'b1, 64'h80, 64'h0, 8'h00, 64'hDEAD, 10, 0,
                1'b0, 1'b1, 64'h0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h1008, 64'h1234, 8'h0F, 64'hBAD0, 3, 0,
                1'b1, 1'b0, 64'h1234, 8'h0F};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h40, 64'hCAFE, 8'hFF, 64'hBAD1, 2, 0,
                1'b1, 1'b0, 64'hCAFE, 8'hFF};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h2000, 64'h5555, 8'h33, 64'hBEEF, 1, 0,
                1'b0, 1'b1, 64'h0, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1, 3,
                1'b0, 1'b1, 64'h0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h8, 64'hAAAA_0000_0000_00AA, 8'h80, 64'hBAD2, 4, 1,
                1'b1, 1'b0, 64'hAAAA_0000_0000_00AA, 8'h80};
    for (int k = 0; k < 6; k++) begin
      set_req(vecs[k].port, vecs[k].in_wen, vecs[k].in_ren, vecs[k].addr, vecs[k].in_wdata, vecs[k].in_wmask);
      push_exp(vecs[k].port, vecs[k].exp_wen, vecs[k].exp_ren, vecs[k].addr, vecs[k].exp_wdata,
               vecs[k].exp_wmask, vecs[k].mem_rdata, vecs[k].lat, vecs[k].hold);
      tick();
      check("grant_latency", wen_mem | ren_mem, 1'b1);
      serve_one(5);
    end
  endtask

  task automatic checkOutput();
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
  endtask

  initial begin
    ui_rst_n = 1'b0;
    valid_mem = 1'b0;
    rdata_mem = 64'h0;
    clear_req(1'b0);
    clear_req(1'b1);
    prdata[0] = 64'h0;
    prdata[1] = 64'h0;
    tick();
    check("rst_state", debug_arb_state, 2'b00);
    check("rst_grant", debug_arb_grant, 1'b0);
    check("rst_mem_req", {wen_mem, ren_mem}, 2'b00);
    check("rst_valid", {p0_valid, p1_valid}, 2'b00);
    check("rst_addr_mem", addr_mem, 64'h0);
    check("rst_rdata", p0_rdata | p1_rdata, 64'h0);
    tick();
    ui_rst_n = 1'b1;
    tick();

    applyStimulus();

    // Reset dropped while a write is outstanding.
    set_req(1'b1, 1'b1, 1'b0, 64'h500, 64'h99, 8'h03);
    tick();
    check("rst_busy_state", debug_arb_state, 2'b01);
    check("rst_busy_wen", wen_mem, 1'b1);
    tick();
    ui_rst_n = 1'b0;
    #1;
    check("abort_mem_req", {wen_mem, ren_mem}, 2'b00);
    check("abort_state", debug_arb_state, 2'b00);
    check("abort_p0_rdata", p0_rdata, 64'h0);
    check("abort_addr_mem", addr_mem, 64'h0);
    prdata[0] = 64'h0;
    prdata[1] = 64'h0;
    clear_req(1'b1);
    tick();
    ui_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", {p0_valid, p1_valid}, 2'b00);
    end

    // Both ports contend and hold their reads.
`ifdef DDR_ARB_ROUND_ROBIN_EN
    arb_order = '{0, 1, 0, 1};
`else
    arb_order = '{0, 0, 0, 0};
`endif
    auto_drop = 1'b0;
    set_req(1'b0, 1'b0, 1'b1, 64'h100, 64'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b1, 64'h200, 64'h0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      push_exp(arb_order[k][0], 1'b0, 1'b1, (arb_order[k] == 0) ? 64'h100 : 64'h200,
               64'h0, 8'h00, 64'h1000 + 64'(k), 1, 0);
      serve_one(6);
    end
    clear_req(1'b0);
    push_exp(1'b1, 1'b0, 1'b1, 64'h200, 64'h0, 8'h00, 64'h2222, 2, 0);
    serve_one(6);
    clear_req(1'b1);
    repeat (3) tick();
    check("final_idle", debug_arb_state, 2'b00);
    check("sb_empty", sb.size(), 0);

    checkOutput();
    $finish;
  end

endmodule
